// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state encoding,
// owner encoding and the request/grant bit positions used by rr_arb2.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_ACK  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Bit positions of each requester in the 2-bit req/gnt vectors
  localparam int IDX_IFU = 0;
  localparam int IDX_LSU = 1;

  // Width of a counter that must hold 0..timeout (at least one bit)
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (IFU, LSU), the arbiter and memory.
//
// Handshake: a requester raises *_req with its payload and holds both stable
// until it sees a one-cycle *_gnt pulse; the grant cycle is the only cycle
// the arbiter samples the payload. Read data comes back as a one-cycle
// *_rvalid pulse (rerr=1 marks a timeout with rdata=0); a write completes
// with a one-cycle ioLsu_wdone pulse. Towards memory, ioMem_ren/ioMem_wen
// are single-cycle commands and ioMem_rvalid is a single-cycle response;
// memory has no back-pressure.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  // IFU (read-only requester)
  logic              ioIfu_req;
  logic [ADDR_W-1:0] ioIfu_addr;
  logic              ioIfu_gnt;
  logic              ioIfu_rvalid;
  logic [DATA_W-1:0] ioIfu_rdata;
  logic              ioIfu_rerr;

  // LSU (read/write requester)
  logic              ioLsu_req;
  logic              ioLsu_wen;
  logic [ADDR_W-1:0] ioLsu_addr;
  logic [DATA_W-1:0] ioLsu_wdata;
  logic [MASK_W-1:0] ioLsu_wmask;
  logic              ioLsu_gnt;
  logic              ioLsu_rvalid;
  logic [DATA_W-1:0] ioLsu_rdata;
  logic              ioLsu_rerr;
  logic              ioLsu_wdone;

  // Memory side
  logic              ioMem_ren;
  logic              ioMem_wen;
  logic [ADDR_W-1:0] ioMem_addr;
  logic [DATA_W-1:0] ioMem_wData;
  logic [MASK_W-1:0] ioMem_wMask;
  logic              ioMem_rvalid;
  logic [DATA_W-1:0] ioMem_rData;

  // Arbiter view
  modport slave (
    input  ioIfu_req, ioIfu_addr,
    output ioIfu_gnt, ioIfu_rvalid, ioIfu_rdata, ioIfu_rerr,
    input  ioLsu_req, ioLsu_wen, ioLsu_addr, ioLsu_wdata, ioLsu_wmask,
    output ioLsu_gnt, ioLsu_rvalid, ioLsu_rdata, ioLsu_rerr, ioLsu_wdone,
    output ioMem_ren, ioMem_wen, ioMem_addr, ioMem_wData, ioMem_wMask,
    input  ioMem_rvalid, ioMem_rData
  );

  // Environment view: requesters plus memory
  modport master (
    output ioIfu_req, ioIfu_addr,
    input  ioIfu_gnt, ioIfu_rvalid, ioIfu_rdata, ioIfu_rerr,
    output ioLsu_req, ioLsu_wen, ioLsu_addr, ioLsu_wdata, ioLsu_wmask,
    input  ioLsu_gnt, ioLsu_rvalid, ioLsu_rdata, ioLsu_rerr, ioLsu_wdone,
    input  ioMem_ren, ioMem_wen, ioMem_addr, ioMem_wData, ioMem_wMask,
    output ioMem_rvalid, ioMem_rData
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright; on a tie the
// requester that did not own the previous transaction wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output logic [1:0] gnt
);

  // One-hot grant selection
  always_comb begin
    gnt = 2'b00;
    if (req[IDX_IFU] && req[IDX_LSU]) begin
      if (last_owner == OWN_LSU) begin
        gnt[IDX_IFU] = 1'b1;
      end else begin
        gnt[IDX_LSU] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU onto a single memory port with one transaction
// outstanding. Reads wait for ioMem_rvalid up to TIMEOUT cycles, then
// complete with rerr=1 and zero data. dbg_state exposes the FSM state.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output arb_state_e    dbg_state
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        arb_gnt;
  logic              ifu_gnt, lsu_gnt, lsu_wdone;
  logic              mem_ren, mem_wen;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [MASK_W-1:0] win_mask;
  logic              rd_done, rd_err;
  logic [DATA_W-1:0] rd_data;
  logic              to_ifu, to_lsu;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.ioLsu_req, bus.ioIfu_req}),
    .last_owner (owner_q),
    .gnt        (arb_gnt)
  );

  // State, owner (doubles as the round-robin last owner) and timeout counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_LSU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and command decode; everything held at zero while in reset
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    ifu_gnt   = 1'b0;
    lsu_gnt   = 1'b0;
    lsu_wdone = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    win_addr  = '0;
    win_data  = '0;
    win_mask  = '0;
    rd_done   = 1'b0;
    rd_err    = 1'b0;
    rd_data   = '0;
    if (reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_gnt[IDX_IFU]) begin
            ifu_gnt  = 1'b1;
            owner_d  = OWN_IFU;
            win_addr = bus.ioIfu_addr;
            mem_ren  = 1'b1;
            cnt_d    = '0;
            state_d  = ST_RD_WAIT;
          end else if (arb_gnt[IDX_LSU]) begin
            lsu_gnt  = 1'b1;
            owner_d  = OWN_LSU;
            win_addr = bus.ioLsu_addr;
            if (bus.ioLsu_wen) begin
              mem_wen  = 1'b1;
              win_data = bus.ioLsu_wdata;
              win_mask = bus.ioLsu_wmask;
              state_d  = ST_WR_ACK;
            end else begin
              mem_ren = 1'b1;
              cnt_d   = '0;
              state_d = ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (bus.ioMem_rvalid) begin
            rd_done = 1'b1;
            rd_data = bus.ioMem_rData;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_MAX) begin
            rd_done = 1'b1;
            rd_err  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WR_ACK: begin
          lsu_wdone = 1'b1;
          state_d   = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Read completion is steered to the current owner only
  assign to_ifu = rd_done && (owner_q == OWN_IFU);
  assign to_lsu = rd_done && (owner_q == OWN_LSU);

  assign bus.ioIfu_gnt    = ifu_gnt;
  assign bus.ioIfu_rvalid = to_ifu;
  assign bus.ioIfu_rdata  = to_ifu ? rd_data : '0;
  assign bus.ioIfu_rerr   = to_ifu && rd_err;

  assign bus.ioLsu_gnt    = lsu_gnt;
  assign bus.ioLsu_rvalid = to_lsu;
  assign bus.ioLsu_rdata  = to_lsu ? rd_data : '0;
  assign bus.ioLsu_rerr   = to_lsu && rd_err;
  assign bus.ioLsu_wdone  = lsu_wdone;

  assign bus.ioMem_ren    = mem_ren;
  assign bus.ioMem_wen    = mem_wen;
  assign bus.ioMem_addr   = win_addr;
  assign bus.ioMem_wData  = win_data;
  assign bus.ioMem_wMask  = win_mask;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a random
// mix, with read data checked through an expected queue.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int MASK_W  = DATA_W / 8;
  localparam int TIMEOUT = 255;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  arb_state_e dbg_state;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [DATA_W:0] exp_q[$];   // {rerr, rdata} of each expected read return

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    bus.ioIfu_req    = 1'b0;
    bus.ioIfu_addr   = '0;
    bus.ioLsu_req    = 1'b0;
    bus.ioLsu_wen    = 1'b0;
    bus.ioLsu_addr   = '0;
    bus.ioLsu_wdata  = '0;
    bus.ioLsu_wmask  = '0;
    bus.ioMem_rvalid = 1'b0;
    bus.ioMem_rData  = '0;
  endtask

  function automatic logic [255:0] all_outputs();
    return 256'({bus.ioIfu_gnt, bus.ioIfu_rvalid, bus.ioIfu_rdata, bus.ioIfu_rerr,
                 bus.ioLsu_gnt, bus.ioLsu_rvalid, bus.ioLsu_rdata, bus.ioLsu_rerr,
                 bus.ioLsu_wdone, bus.ioMem_ren, bus.ioMem_wen, bus.ioMem_addr,
                 bus.ioMem_wData, bus.ioMem_wMask});
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.ioIfu_req = 1'b1; bus.ioLsu_req = 1'b1; bus.ioLsu_wen = 1'b1;
    bus.ioIfu_addr = 32'h1234; bus.ioLsu_addr = 32'h5678;
    bus.ioMem_rvalid = 1'b1; bus.ioMem_rData = 64'hFFFF;
    #3;
    checks++;
    if (all_outputs() !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", all_outputs());
    end
    step(); step(); settle();
    checks++;
    if (all_outputs() !== '0) begin
      failures++; $display("FAIL reset_outputs_held: got %h expected 0", all_outputs());
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    drive_idle();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_ifu_read();
    logic [DATA_W:0] e;
    step();
    bus.ioIfu_req = 1'b1; bus.ioIfu_addr = 32'h8000_0000;
    settle();
    checks++;
    if ({bus.ioIfu_gnt, bus.ioLsu_gnt, bus.ioMem_ren, bus.ioMem_wen} !== 4'b1010) begin
      failures++; $display("FAIL ifu_read_grant: got %b expected 1010",
                           {bus.ioIfu_gnt, bus.ioLsu_gnt, bus.ioMem_ren, bus.ioMem_wen});
    end
    checks++;
    if (bus.ioMem_addr !== 32'h8000_0000) begin
      failures++; $display("FAIL ifu_read_addr: got %h expected 80000000", bus.ioMem_addr);
    end
    exp_q.push_back({1'b0, 64'h1122_3344_5566_7788});
    step();
    bus.ioIfu_req = 1'b0;
    bus.ioMem_rvalid = 1'b1; bus.ioMem_rData = 64'h1122_3344_5566_7788;
    settle();
    checks++;
    if (bus.ioIfu_rvalid !== 1'b1) begin
      failures++; $display("FAIL ifu_read_rvalid: got %b expected 1", bus.ioIfu_rvalid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.ioIfu_rerr, bus.ioIfu_rdata} !== e) begin
        failures++; $display("FAIL ifu_read_data: got %h expected %h", {bus.ioIfu_rerr, bus.ioIfu_rdata}, e);
      end
    end
    checks++;
    if ({bus.ioLsu_rvalid, bus.ioLsu_rdata} !== '0) begin
      failures++; $display("FAIL ifu_read_lsu_quiet: got %h expected 0", {bus.ioLsu_rvalid, bus.ioLsu_rdata});
    end
    step();
    bus.ioMem_rvalid = 1'b0; bus.ioMem_rData = '0;
    settle();
    checks++;
    if (bus.ioIfu_rvalid !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL ifu_read_done: got rvalid=%b state=%0d expected 0/IDLE", bus.ioIfu_rvalid, dbg_state);
    end
  endtask

  task automatic test_lsu_write();
    logic [ADDR_W+DATA_W+MASK_W+1:0] got_cmd, exp_cmd;
    step();
    bus.ioLsu_req = 1'b1; bus.ioLsu_wen = 1'b1; bus.ioLsu_addr = 32'h8000_0010;
    bus.ioLsu_wdata = 64'hDEAD_BEEF; bus.ioLsu_wmask = 8'h0F;
    settle();
    exp_cmd = {1'b0, 1'b1, 32'h8000_0010, 64'hDEAD_BEEF, 8'h0F};
    got_cmd = {bus.ioMem_ren, bus.ioMem_wen, bus.ioMem_addr, bus.ioMem_wData, bus.ioMem_wMask};
    checks++;
    if (got_cmd !== exp_cmd || bus.ioLsu_gnt !== 1'b1) begin
      failures++; $display("FAIL lsu_write_cmd: got %h gnt=%b expected %h gnt=1", got_cmd, bus.ioLsu_gnt, exp_cmd);
    end
    step();
    bus.ioLsu_req = 1'b0;
    bus.ioMem_rvalid = 1'b1; bus.ioMem_rData = 64'hBAD0_BAD0;   // must be ignored in WR_ACK
    settle();
    checks++;
    if ({bus.ioLsu_wdone, bus.ioLsu_rvalid, bus.ioIfu_rvalid, bus.ioMem_wen} !== 4'b1000) begin
      failures++; $display("FAIL lsu_write_wdone: got %b expected 1000",
                           {bus.ioLsu_wdone, bus.ioLsu_rvalid, bus.ioIfu_rvalid, bus.ioMem_wen});
    end
    step();
    bus.ioMem_rvalid = 1'b0; bus.ioMem_rData = '0;
    settle();
    checks++;
    if (bus.ioLsu_wdone !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL lsu_write_end: got wdone=%b state=%0d expected 0/IDLE", bus.ioLsu_wdone, dbg_state);
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    owner_e          exp_owner = OWN_IFU;
    owner_e          rd_owner  = OWN_IFU;
    logic            rsp_pend  = 1'b0;
    logic [DATA_W-1:0] rsp_data = '0;
    logic [DATA_W:0] e;
    int              grants = 0;
    step();
    bus.ioIfu_req = 1'b1; bus.ioIfu_addr = 32'h100;
    bus.ioLsu_req = 1'b1; bus.ioLsu_wen = 1'b0; bus.ioLsu_addr = 32'h200;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      bus.ioMem_rvalid = rsp_pend;
      bus.ioMem_rData  = rsp_pend ? rsp_data : '0;
      rsp_pend = 1'b0;
      settle();
      checks++;
      if ((bus.ioIfu_gnt | bus.ioLsu_gnt) !== ((c % 2) == 0)) begin
        failures++; $display("FAIL b2b_spacing c=%0d: got %b expected %b", c, bus.ioIfu_gnt | bus.ioLsu_gnt, (c % 2) == 0);
      end
      if (bus.ioIfu_gnt || bus.ioLsu_gnt) begin
        checks++;
        if ({bus.ioLsu_gnt, bus.ioIfu_gnt} !== ((exp_owner == OWN_IFU) ? 2'b01 : 2'b10)) begin
          failures++; $display("FAIL b2b_order c=%0d: got %b expected owner %0d", c, {bus.ioLsu_gnt, bus.ioIfu_gnt}, exp_owner);
        end
        grants++;
        rd_owner  = exp_owner;
        exp_owner = (exp_owner == OWN_IFU) ? OWN_LSU : OWN_IFU;
        rsp_data  = {$urandom, $urandom};
        rsp_pend  = 1'b1;
        exp_q.push_back({1'b0, rsp_data});
      end
      if (bus.ioIfu_rvalid || bus.ioLsu_rvalid) begin
        e = exp_q.pop_front();
        checks++;
        if (rd_owner == OWN_IFU ? ({bus.ioIfu_rerr, bus.ioIfu_rdata} !== e || bus.ioLsu_rvalid)
                                : ({bus.ioLsu_rerr, bus.ioLsu_rdata} !== e || bus.ioIfu_rvalid)) begin
          failures++; $display("FAIL b2b_rdata c=%0d: got ifu=%h lsu=%h expected %h to owner %0d",
                               c, bus.ioIfu_rdata, bus.ioLsu_rdata, e, rd_owner);
        end
      end
    end
    checks++;
    if (grants != 4 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_count: got grants=%0d pending=%0d expected 4/0", grants, exp_q.size());
    end
    step();
    drive_idle();
  endtask

  task automatic test_timeout();
    int   got_k = -1;
    logic lsu_early = 1'b0;
    logic [DATA_W:0] e;
    step();
    bus.ioIfu_req = 1'b1; bus.ioIfu_addr = $urandom;
    settle();
    checks++;
    if (bus.ioIfu_gnt !== 1'b1) begin
      failures++; $display("FAIL timeout_grant: got %b expected 1", bus.ioIfu_gnt);
    end
    exp_q.push_back({1'b1, {DATA_W{1'b0}}});
    for (int k = 1; k <= 300; k++) begin
      step();
      bus.ioIfu_req = 1'b0;
      bus.ioLsu_req = 1'b1; bus.ioLsu_wen = 1'b0; bus.ioLsu_addr = 32'h44;
      settle();
      if (bus.ioLsu_gnt) lsu_early = 1'b1;
      if (bus.ioIfu_rvalid) begin
        got_k = k;
        e = exp_q.pop_front();
        checks++;
        if ({bus.ioIfu_rerr, bus.ioIfu_rdata} !== e) begin
          failures++; $display("FAIL timeout_data: got %h expected %h", {bus.ioIfu_rerr, bus.ioIfu_rdata}, e);
        end
        break;
      end
    end
    checks++;
    if (got_k != TIMEOUT + 1) begin
      failures++; $display("FAIL timeout_latency: got %0d expected %0d", got_k, TIMEOUT + 1);
    end
    checks++;
    if (lsu_early !== 1'b0) begin
      failures++; $display("FAIL timeout_no_grant_while_busy: got %b expected 0", lsu_early);
    end
    step();
    settle();
    checks++;
    if (bus.ioLsu_gnt !== 1'b1 || bus.ioMem_ren !== 1'b1) begin
      failures++; $display("FAIL timeout_next_grant: got gnt=%b ren=%b expected 1/1", bus.ioLsu_gnt, bus.ioMem_ren);
    end
    exp_q.push_back({1'b0, 64'h5A5A});
    step();
    bus.ioLsu_req = 1'b0; bus.ioMem_rvalid = 1'b1; bus.ioMem_rData = 64'h5A5A;
    settle();
    if (bus.ioLsu_rvalid) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.ioLsu_rerr, bus.ioLsu_rdata} !== e) begin
        failures++; $display("FAIL timeout_lsu_data: got %h expected %h", {bus.ioLsu_rerr, bus.ioLsu_rdata}, e);
      end
    end else begin
      checks++; failures++;
      $display("FAIL timeout_lsu_rvalid: got 0 expected 1");
      void'(exp_q.pop_front());
    end
    step();
    drive_idle();
  endtask

  task automatic test_reset_abort();
    logic [DATA_W:0] e;
    step();
    bus.ioIfu_req = 1'b1; bus.ioIfu_addr = 32'h300;
    settle();
    checks++;
    if (bus.ioIfu_gnt !== 1'b1) begin
      failures++; $display("FAIL abort_grant: got %b expected 1", bus.ioIfu_gnt);
    end
    step();
    bus.ioIfu_req = 1'b0;
    step();
    rst_n = 1'b0;
    settle();
    checks++;
    if (all_outputs() !== '0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL abort_in_reset: got out=%h state=%0d expected 0/IDLE", all_outputs(), dbg_state);
    end
    step();
    rst_n = 1'b1;
    bus.ioMem_rvalid = 1'b1; bus.ioMem_rData = 64'hC0FFEE;
    settle();
    checks++;
    if (bus.ioIfu_rvalid !== 1'b0 || bus.ioLsu_rvalid !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL abort_late_rvalid: got %b%b state=%0d expected 00/IDLE",
                           bus.ioIfu_rvalid, bus.ioLsu_rvalid, dbg_state);
    end
    step();
    bus.ioIfu_req = 1'b1; bus.ioLsu_req = 1'b1; bus.ioLsu_wen = 1'b0;
    settle();
    checks++;
    if ({bus.ioLsu_gnt, bus.ioIfu_gnt, bus.ioIfu_rvalid} !== 3'b010) begin
      failures++; $display("FAIL abort_tie_ifu: got %b expected 010",
                           {bus.ioLsu_gnt, bus.ioIfu_gnt, bus.ioIfu_rvalid});
    end
    exp_q.push_back({1'b0, 64'hC0FFEE});
    step();
    bus.ioIfu_req = 1'b0;
    settle();
    checks++;
    if (bus.ioIfu_rvalid !== 1'b1) begin
      failures++; $display("FAIL abort_ifu_rvalid: got %b expected 1", bus.ioIfu_rvalid);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.ioIfu_rerr, bus.ioIfu_rdata} !== e) begin
        failures++; $display("FAIL abort_ifu_data: got %h expected %h", {bus.ioIfu_rerr, bus.ioIfu_rdata}, e);
      end
    end
    step();
    bus.ioMem_rvalid = 1'b0;
    settle();
    checks++;
    if (bus.ioLsu_gnt !== 1'b1) begin
      failures++; $display("FAIL abort_lsu_grant: got %b expected 1", bus.ioLsu_gnt);
    end
    step();
    bus.ioLsu_req = 1'b0; bus.ioMem_rvalid = 1'b1; bus.ioMem_rData = 64'h77;
    settle();
    checks++;
    if ({bus.ioLsu_rvalid, bus.ioLsu_rerr, bus.ioLsu_rdata} !== {2'b10, 64'h77}) begin
      failures++; $display("FAIL abort_lsu_data: got %b %h expected 1 77", bus.ioLsu_rvalid, bus.ioLsu_rdata);
    end
    step();
    drive_idle();
  endtask

  task automatic test_random();
    int                n_cyc   = 300;
    int                m_state = 0;          // 0 idle, 1 read wait, 2 write ack
    owner_e            m_last  = OWN_LSU;
    owner_e            m_owner = OWN_LSU;
    int                lat     = 0;
    logic [DATA_W-1:0] rsp_data = '0;
    logic              ifu_gp = 1'b0, lsu_gp = 1'b0, deliver;
    logic [1:0]        exp_g, exp_rv;
    logic [ADDR_W+DATA_W+MASK_W+1:0] exp_cmd, got_cmd;
    logic [DATA_W:0]   e;
    for (int c = 0; c < n_cyc; c++) begin
      step();
      if (!bus.ioIfu_req || ifu_gp) begin
        bus.ioIfu_req  = (c < n_cyc - 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.ioIfu_addr = $urandom;
      end
      if (!bus.ioLsu_req || lsu_gp) begin
        bus.ioLsu_req   = (c < n_cyc - 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.ioLsu_wen   = 1'($urandom_range(0, 1));
        bus.ioLsu_addr  = $urandom;
        bus.ioLsu_wdata = {$urandom, $urandom};
        bus.ioLsu_wmask = 8'($urandom);
      end
      deliver = (m_state == 1) && (lat == 0);
      if (deliver) begin
        bus.ioMem_rvalid = 1'b1; bus.ioMem_rData = rsp_data;
      end else begin
        bus.ioMem_rvalid = (m_state != 1) && ($urandom_range(0, 3) == 0);
        bus.ioMem_rData  = {$urandom, $urandom};
      end
      settle();
      exp_g = 2'b00;
      if (m_state == 0) begin
        if (bus.ioIfu_req && bus.ioLsu_req) exp_g = (m_last == OWN_LSU) ? 2'b01 : 2'b10;
        else exp_g = {bus.ioLsu_req, bus.ioIfu_req};
      end
      checks++;
      if ({bus.ioLsu_gnt, bus.ioIfu_gnt} !== exp_g) begin
        failures++; $display("FAIL rand_grant c=%0d: got %b expected %b", c, {bus.ioLsu_gnt, bus.ioIfu_gnt}, exp_g);
      end
      exp_cmd = '0;
      if (exp_g[1] && bus.ioLsu_wen)
        exp_cmd = {1'b0, 1'b1, bus.ioLsu_addr, bus.ioLsu_wdata, bus.ioLsu_wmask};
      else if (exp_g[1])
        exp_cmd = {1'b1, 1'b0, bus.ioLsu_addr, {DATA_W{1'b0}}, {MASK_W{1'b0}}};
      else if (exp_g[0])
        exp_cmd = {1'b1, 1'b0, bus.ioIfu_addr, {DATA_W{1'b0}}, {MASK_W{1'b0}}};
      got_cmd = {bus.ioMem_ren, bus.ioMem_wen, bus.ioMem_addr, bus.ioMem_wData, bus.ioMem_wMask};
      checks++;
      if (got_cmd !== exp_cmd) begin
        failures++; $display("FAIL rand_cmd c=%0d: got %h expected %h", c, got_cmd, exp_cmd);
      end
      exp_rv = 2'b00;
      if (deliver) exp_rv = (m_owner == OWN_IFU) ? 2'b01 : 2'b10;
      checks++;
      if ({bus.ioLsu_rvalid, bus.ioIfu_rvalid} !== exp_rv) begin
        failures++; $display("FAIL rand_rvalid c=%0d: got %b expected %b", c, {bus.ioLsu_rvalid, bus.ioIfu_rvalid}, exp_rv);
      end
      if (bus.ioIfu_rvalid || bus.ioLsu_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rand_unexpected_rdata c=%0d: got return expected none", c);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ((bus.ioIfu_rvalid ? {bus.ioIfu_rerr, bus.ioIfu_rdata} : {bus.ioLsu_rerr, bus.ioLsu_rdata}) !== e) begin
            failures++; $display("FAIL rand_rdata c=%0d: got ifu=%h lsu=%h expected %h", c, bus.ioIfu_rdata, bus.ioLsu_rdata, e);
          end
        end
      end
      checks++;
      if (bus.ioLsu_wdone !== (m_state == 2)) begin
        failures++; $display("FAIL rand_wdone c=%0d: got %b expected %b", c, bus.ioLsu_wdone, m_state == 2);
      end
      if (m_state == 1) begin
        if (deliver) m_state = 0;
        else lat--;
      end else if (m_state == 2) begin
        m_state = 0;
      end else if (exp_g != 2'b00) begin
        m_owner = exp_g[0] ? OWN_IFU : OWN_LSU;
        m_last  = m_owner;
        if (exp_g[1] && bus.ioLsu_wen) begin
          m_state = 2;
        end else begin
          m_state  = 1;
          lat      = $urandom_range(0, 3);
          rsp_data = {$urandom, $urandom};
          exp_q.push_back({1'b0, rsp_data});
        end
      end
      ifu_gp = bus.ioIfu_gnt;
      lsu_gp = bus.ioLsu_gnt;
    end
    drive_idle();
    checks++;
    if (exp_q.size() != 0 || m_state != 0) begin
      failures++; $display("FAIL rand_drain: got pending=%0d state=%0d expected 0/0", exp_q.size(), m_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_back_to_back();
    test_timeout();
    test_reset_abort();
    test_random();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; mask width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles to wait for ioMem_rvalid.
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have IFU ports: ioIfu_req in 1; ioIfu_addr in ADDR_W; ioIfu_gnt out 1; ioIfu_rvalid out 1; ioIfu_rdata out DATA_W; ioIfu_rerr out 1.
REQ-007 SHALL have LSU ports: ioLsu_req in 1; ioLsu_wen in 1; ioLsu_addr in ADDR_W; ioLsu_wdata in DATA_W; ioLsu_wmask in DATA_W/8; ioLsu_gnt out 1; ioLsu_rvalid out 1; ioLsu_rdata out DATA_W; ioLsu_rerr out 1; ioLsu_wdone out 1.
REQ-008 SHALL have memory ports: ioMem_ren out 1; ioMem_wen out 1; ioMem_addr out ADDR_W; ioMem_wData out DATA_W; ioMem_wMask out DATA_W/8; ioMem_rvalid in 1; ioMem_rData in DATA_W.

Function
REQ-009 SHALL have FSM states IDLE, RD_WAIT, WR_ACK; exactly one memory transaction outstanding at a time.
REQ-010 Requester SHALL hold req and payload stable until its gnt; gnt is a one-cycle pulse, only in IDLE.
REQ-011 In IDLE with one req high, that requester SHALL be granted the same cycle.
REQ-012 In IDLE with both req high, the requester not granted last SHALL win (round-robin); last-owner register resets to LSU, so IFU wins the first tie.
REQ-013 Grant cycle SHALL drive ioMem_addr/ren/wen/wData/wMask combinationally from the winner; ioMem_wen only for LSU with ioLsu_wen=1; ren and wen never both high.
REQ-014 Read grant: IDLE->RD_WAIT; timeout counter cleared to 0.
REQ-015 RD_WAIT with ioMem_rvalid=1: SHALL pulse owner's rvalid for that cycle with rdata=ioMem_rData, rerr=0; ->IDLE.
REQ-016 RD_WAIT without rvalid: counter +1; when counter reaches TIMEOUT, SHALL pulse owner's rvalid with rdata=0, rerr=1; ->IDLE.
REQ-017 Write grant: IDLE->WR_ACK; WR_ACK SHALL pulse ioLsu_wdone one cycle; ->IDLE.
REQ-018 No grant in RD_WAIT/WR_ACK or in the cycle of return to IDLE; minimum spacing between grants is 2 cycles.
REQ-019 ioMem_rvalid in IDLE or WR_ACK SHALL be ignored.
REQ-020 Non-owner rvalid/rdata SHALL be 0; all memory command outputs 0 outside grant cycles.

Reset
REQ-021 reset low SHALL asynchronously force IDLE, counter 0, last-owner LSU.
REQ-022 During reset all outputs SHALL be 0.
REQ-023 Reset mid-RD_WAIT/WR_ACK SHALL abort the transaction with no rvalid/wdone pulse after release.

Structure
REQ-024 State encoding and owner encoding (IFU=0, LSU=1) SHALL live in shared package mem_arb_pkg.
REQ-025 Round-robin selection SHALL be sub-module rr_arb2 (2 reqs, last-owner in, one-hot grant out); FSM and counter in mem_arbiter.

Verification
REQ-026 IFU read 0x80000000, memory returns 0x1122334455667788 next cycle -> ioIfu_gnt at cycle 0, ioIfu_rvalid with that data at cycle 1, rerr=0.
REQ-027 LSU write 0x80000010, wdata 0xDEADBEEF, wmask 0x0F -> ioMem_wen one cycle with those values, ioLsu_wdone next cycle.
REQ-028 Both req held continuously, 1-cycle memory -> grants IFU, LSU, IFU, LSU every 2 cycles.
REQ-029 IFU read, rvalid never asserted, TIMEOUT=255 -> ioIfu_rvalid=1, rerr=1, rdata=0 exactly 256 cycles after grant.
REQ-030 reset low in RD_WAIT, then late ioMem_rvalid after release -> no rvalid, FSM IDLE, next tie grants IFU.
